// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the AXI4 read-port arbiter.
//   arb_state_t : arbiter FSM states (idle / address phase / data phase)
//   ReqDisp     : requester index of the display fetch path
//   ReqDraw     : requester index of the drawing engine read path
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } arb_state_t;

  localparam int unsigned ReqDisp = 0;
  localparam int unsigned ReqDraw = 1;

endpackage

// File: rtl/rd_arb_sel.sv
// Requester selection for the AXI read arbiter, plus the starvation-guard counter.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   arvalid_i      : pending address requests, bit i = requester i
//   grant_i        : a grant is taken this cycle (counter update strobe)
//   sel_valid_o    : at least one requester is pending
//   sel_o          : index of the selected requester
module rd_arb_sel
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned MaxConsec = 4,
  localparam int unsigned CntW = $clog2(MaxConsec + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] arvalid_i,
  input  logic       grant_i,
  output logic       sel_valid_o,
  output logic       sel_o
);

  logic [CntW-1:0] consec_cnt_q, consec_cnt_d;
  logic            cnt_at_max;

  assign cnt_at_max = (consec_cnt_q == CntW'(MaxConsec));

  // Display wins ties until it has taken MaxConsec grants in a row while
  // the drawing engine was waiting.
  always_comb begin
    sel_valid_o = |arvalid_i;
    sel_o       = 1'b0;
    if (arvalid_i[ReqDisp] && arvalid_i[ReqDraw]) begin
      sel_o = cnt_at_max;
    end else begin
      sel_o = arvalid_i[ReqDraw];
    end
  end

  always_comb begin
    consec_cnt_d = consec_cnt_q;
    if (grant_i) begin
      if (!sel_o && arvalid_i[ReqDraw]) begin
        consec_cnt_d = cnt_at_max ? consec_cnt_q : consec_cnt_q + 1'b1;
      end else begin
        consec_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      consec_cnt_q <= '0;
    end else begin
      consec_cnt_q <= consec_cnt_d;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-requester arbiter for the single AXI4 read master port.
// Requester 0 is the display fetch path, requester 1 the drawing engine.
// One burst is owned at a time: the winning AR beat is latched, replayed on
// the master AR channel, and R beats are steered back to the owner until RLAST.
//   ACLK, ARST          : clock, asynchronous active-high reset
//   S_AR*               : per-requester address channels (packed, requester i at slice i)
//   S_R*                : per-requester read channels (data/resp/last shared, qualified by S_RVALID)
//   M_AXI_AR*, M_AXI_R* : master read port
//   GRANT               : registered one-hot owner, 0 while idle
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
  parameter int unsigned MAX_CONSEC         = 4
) (
  input  logic                            ACLK,
  input  logic                            ARST,
  input  logic [1:0]                      S_ARVALID,
  output logic [1:0]                      S_ARREADY,
  input  logic [2*C_M_AXI_ADDR_WIDTH-1:0] S_ARADDR,
  input  logic [15:0]                     S_ARLEN,
  output logic [1:0]                      S_RVALID,
  input  logic [1:0]                      S_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]                      S_RRESP,
  output logic                            S_RLAST,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  output logic [1:0]                      GRANT
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;

  arb_state_t    state_q, state_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    arready_raw;
  logic          sel, sel_valid, take;

  assign take = (state_q == StIdle) && sel_valid;

  rd_arb_sel #(
    .MaxConsec (MAX_CONSEC)
  ) u_sel (
    .clk_i       (ACLK),
    .rst_i       (ARST),
    .arvalid_i   (S_ARVALID),
    .grant_i     (take),
    .sel_valid_o (sel_valid),
    .sel_o       (sel)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    len_d         = len_q;
    grant_d       = grant_q;
    arready_raw   = 2'b00;
    S_RVALID      = 2'b00;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          arready_raw[sel] = 1'b1;
          owner_d          = sel;
          addr_d           = sel ? S_ARADDR[2*AW-1:AW] : S_ARADDR[AW-1:0];
          len_d            = sel ? S_ARLEN[15:8] : S_ARLEN[7:0];
          grant_d          = sel ? 2'b10 : 2'b01;
          state_d          = StAddr;
        end
      end
      StAddr: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) begin
          state_d = StData;
        end
      end
      StData: begin
        S_RVALID[owner_q] = M_AXI_RVALID;
        M_AXI_RREADY      = S_RREADY[owner_q];
        if (M_AXI_RVALID && S_RREADY[owner_q] && M_AXI_RLAST) begin
          state_d = StIdle;
          grant_d = 2'b00;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State is already IDLE during reset; mask the accept so nothing looks granted.
  assign S_ARREADY    = arready_raw & {2{~ARST}};
  assign S_RDATA      = M_AXI_RDATA;
  assign S_RRESP      = M_AXI_RRESP;
  assign S_RLAST      = M_AXI_RLAST;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_ARLEN  = len_q;
  assign GRANT        = grant_q;

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: scenario tasks drive randomized traffic
// through a simple slave/requester driver and compare against expectations derived
// from the arbitration rules.
module tb_axi_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MC = 4;

  logic          aclk = 1'b0;
  logic          arst = 1'b1;
  logic [1:0]    s_arvalid = 2'b00, s_arready, s_rvalid, s_rready = 2'b11, s_rresp;
  logic [2*AW-1:0] s_araddr = '0;
  logic [15:0]   s_arlen = '0;
  logic [DW-1:0] s_rdata, m_rdata = '0;
  logic          s_rlast, m_arvalid, m_arready = 1'b0, m_rvalid = 1'b0, m_rready;
  logic          m_rlast = 1'b0;
  logic [1:0]    m_rresp = 2'b00, grant;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;

  // Observations from the last served burst.
  logic [1:0]    obs_acc, obs_gnt;
  logic [AW-1:0] obs_addr;
  logic [7:0]    obs_len;
  int obs_held, obs_steer_bad, obs_beat_bad, obs_arrdy_bad, obs_stall_cyc, obs_stall_hi;
  int obs_wait, obs_arv_cyc;
  bit obs_to;
  logic [DW-1:0] sent[$];
  logic [DW-1:0] got[$];

  axi_rd_arbiter #(
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_M_AXI_DATA_WIDTH (DW),
    .MAX_CONSEC         (MC)
  ) dut (
    .ACLK          (aclk),
    .ARST          (arst),
    .S_ARVALID     (s_arvalid),
    .S_ARREADY     (s_arready),
    .S_ARADDR      (s_araddr),
    .S_ARLEN       (s_arlen),
    .S_RVALID      (s_rvalid),
    .S_RREADY      (s_rready),
    .S_RDATA       (s_rdata),
    .S_RRESP       (s_rresp),
    .S_RLAST       (s_rlast),
    .M_AXI_ARVALID (m_arvalid),
    .M_AXI_ARREADY (m_arready),
    .M_AXI_ARADDR  (m_araddr),
    .M_AXI_ARLEN   (m_arlen),
    .M_AXI_RVALID  (m_rvalid),
    .M_AXI_RREADY  (m_rready),
    .M_AXI_RDATA   (m_rdata),
    .M_AXI_RRESP   (m_rresp),
    .M_AXI_RLAST   (m_rlast),
    .GRANT         (grant)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;

  // Driver: called at a falling edge with requests already set up. Waits for an
  // accept, plays the slave AR side (ar_delay stall cycles), then returns len+1
  // beats with random gaps. stall_at: beat where the owner holds RREADY low for
  // 5 cycles. raise_at: beat where requester 1 raises ARVALID. abort_at: return
  // at the start of that beat, leaving the burst in flight.
  task automatic serve(input int ar_delay, input int gap_max, input logic [1:0] persist,
                       input int stall_at, input int raise_at, input int abort_at);
    int guard, gap, own, stall_left;
    logic [DW-1:0] d;
    logic [1:0] resp;
    bit hs;
    obs_acc = 2'b00; obs_gnt = 2'b00; obs_addr = '0; obs_len = '0;
    obs_held = 0; obs_steer_bad = 0; obs_beat_bad = 0; obs_arrdy_bad = 0;
    obs_stall_cyc = 0; obs_stall_hi = 0; obs_wait = 0; obs_arv_cyc = 0; obs_to = 0;
    sent.delete();
    got.delete();
    guard = 0;
    while (1) begin
      #1;
      if ((s_arready & s_arvalid) != 2'b00) break;
      guard++;
      if (guard > 50) begin
        obs_to = 1;
        return;
      end
      @(negedge aclk);
      obs_wait++;
    end
    obs_acc = s_arready;
    own = obs_acc[1] ? 1 : 0;
    @(negedge aclk);
    s_arvalid = s_arvalid & ~(obs_acc & ~persist);
    for (int i = 0; i <= ar_delay; i++) begin
      #1;
      if (i == 0) begin
        obs_gnt = grant; obs_addr = m_araddr; obs_len = m_arlen; obs_arv_cyc = cyc_cnt;
      end
      if (m_arvalid === 1'b1 && m_araddr === obs_addr && m_arlen === obs_len) obs_held++;
      m_arready = (i == ar_delay);
      @(negedge aclk);
    end
    m_arready  = 1'b0;
    stall_left = 5;
    guard      = 0;
    for (int beat = 0; beat <= int'(obs_len); beat++) begin
      if (beat == abort_at) begin
        m_rvalid = 1'b1;
        return;
      end
      if (beat == raise_at) s_arvalid[1] = 1'b1;
      gap  = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      d    = {$urandom, $urandom};
      resp = 2'($urandom_range(3, 0));
      while (1) begin
        m_rvalid = (gap == 0);
        if (gap > 0) gap--;
        m_rdata = d;
        m_rresp = resp;
        m_rlast = (beat == int'(obs_len));
        if (beat == stall_at && stall_left > 0 && m_rvalid) begin
          s_rready[own] = 1'b0;
          stall_left--;
          obs_stall_cyc++;
        end else begin
          s_rready = 2'b11;
        end
        #1;
        if (s_rvalid !== (m_rvalid ? obs_acc : 2'b00) || m_rready !== s_rready[own] ||
            m_arvalid !== 1'b0) obs_steer_bad++;
        if (s_arready !== 2'b00) obs_arrdy_bad++;
        if (s_rready[own] == 1'b0 && m_rready !== 1'b0) obs_stall_hi++;
        hs = m_rvalid && m_rready;
        if (hs) begin
          sent.push_back(d);
          if (s_rlast !== m_rlast || s_rresp !== resp) obs_beat_bad++;
        end
        if (s_rvalid[own] && s_rready[own]) got.push_back(s_rdata);
        @(negedge aclk);
        guard++;
        if (guard > 400) begin
          obs_to = 1;
          m_rvalid = 1'b0;
          return;
        end
        if (hs) break;
      end
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    s_rready = 2'b11;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    s_arvalid = 2'b11;
    s_arlen = 16'h0505;
    repeat (2) @(negedge aclk);
    #1;
    n_tests++;
    if (s_arready !== 2'b00) begin
      n_fail++; $display("FAIL reset_arready: got %b want 00", s_arready);
    end
    n_tests++;
    if (s_rvalid !== 2'b00) begin
      n_fail++; $display("FAIL reset_rvalid: got %b want 00", s_rvalid);
    end
    n_tests++;
    if ({m_arvalid, m_rready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_m_valid_ready: got %b want 00", {m_arvalid, m_rready});
    end
    n_tests++;
    if (m_araddr !== '0 || m_arlen !== 8'd0) begin
      n_fail++; $display("FAIL reset_m_addr_len: got %h/%0d want 0/0", m_araddr, m_arlen);
    end
    n_tests++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL reset_grant: got %b want 00", grant);
    end
    s_arvalid = 2'b00;
    @(negedge aclk);
    arst = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_single_burst();
    int dmis;
    s_araddr[AW-1:0] = 32'h1000;
    s_arlen[7:0]     = 8'd15;
    s_arvalid        = 2'b01;
    serve(3, 0, 2'b00, -1, -1, -1);
    n_tests++;
    if (obs_to || obs_acc !== 2'b01 || obs_gnt !== 2'b01) begin
      n_fail++; $display("FAIL single_grant: acc %b gnt %b to %0d want 01 01 0",
                         obs_acc, obs_gnt, obs_to);
    end
    n_tests++;
    if (obs_addr !== 32'h1000 || obs_len !== 8'd15) begin
      n_fail++; $display("FAIL single_ar: got %h/%0d want 1000/15", obs_addr, obs_len);
    end
    n_tests++;
    if (obs_held !== 4) begin
      n_fail++; $display("FAIL single_ar_held: got %0d cycles want 4", obs_held);
    end
    dmis = (got.size() != 16 || sent.size() != 16) ? 1 : 0;
    foreach (sent[i]) if (i < got.size() && got[i] !== sent[i]) dmis++;
    n_tests++;
    if (dmis != 0 || obs_steer_bad != 0 || obs_beat_bad != 0) begin
      n_fail++; $display("FAIL single_data: mis %0d steer %0d beat %0d want 0 0 0",
                         dmis, obs_steer_bad, obs_beat_bad);
    end
    #1;
    n_tests++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL single_grant_clear: got %b want 00", grant);
    end
  endtask

  task automatic test_priority();
    int cnt, exp_w, dmis;
    cnt = 0;
    s_arvalid = 2'b11;
    for (int k = 0; k < 10; k++) begin
      s_araddr = {$urandom, $urandom};
      s_arlen  = {8'($urandom_range(3, 0)), 8'($urandom_range(3, 0))};
      exp_w = (cnt == MC) ? 1 : 0;
      cnt   = (exp_w == 1) ? 0 : cnt + 1;
      serve(int'($urandom_range(2, 0)), 1, 2'b11, -1, -1, -1);
      n_tests++;
      if (obs_to || obs_acc !== (exp_w == 1 ? 2'b10 : 2'b01) ||
          obs_addr !== s_araddr[exp_w*AW +: AW] || obs_len !== s_arlen[exp_w*8 +: 8]) begin
        n_fail++; $display("FAIL prio_grant[%0d]: acc %b addr %h len %0d want owner %0d",
                           k, obs_acc, obs_addr, obs_len, exp_w);
      end
      dmis = (got.size() != sent.size() || sent.size() != int'(s_arlen[exp_w*8 +: 8]) + 1);
      foreach (sent[i]) if (i < got.size() && got[i] !== sent[i]) dmis++;
      n_tests++;
      if (dmis != 0 || obs_steer_bad != 0) begin
        n_fail++; $display("FAIL prio_data[%0d]: mis %0d steer %0d want 0 0",
                           k, dmis, obs_steer_bad);
      end
    end
    s_arvalid = 2'b00;
  endtask

  task automatic test_rready_stall();
    int dmis;
    s_araddr[AW-1:0] = $urandom;
    s_arlen[7:0]     = 8'd15;
    s_arvalid        = 2'b01;
    serve(1, 0, 2'b00, 6, -1, -1);
    n_tests++;
    if (obs_stall_cyc != 5 || obs_stall_hi != 0 || obs_steer_bad != 0) begin
      n_fail++; $display("FAIL stall_rready: stall %0d hi %0d steer %0d want 5 0 0",
                         obs_stall_cyc, obs_stall_hi, obs_steer_bad);
    end
    dmis = (got.size() != 16 || sent.size() != 16) ? 1 : 0;
    foreach (sent[i]) if (i < got.size() && got[i] !== sent[i]) dmis++;
    n_tests++;
    if (dmis != 0) begin
      n_fail++; $display("FAIL stall_data: got %0d mismatches want 0", dmis);
    end
  endtask

  task automatic test_late_req1();
    logic [AW-1:0] a1;
    a1 = $urandom;
    s_araddr = {a1, 32'($urandom)};
    s_arlen  = {8'd2, 8'd7};
    s_arvalid = 2'b01;
    serve(0, 1, 2'b00, -1, 3, -1);
    n_tests++;
    if (obs_arrdy_bad != 0 || obs_acc !== 2'b01) begin
      n_fail++; $display("FAIL late_no_accept: arready cycles %0d acc %b want 0 01",
                         obs_arrdy_bad, obs_acc);
    end
    #1;
    n_tests++;
    if (s_arready !== 2'b10) begin
      n_fail++; $display("FAIL late_first_idle: got %b want 10", s_arready);
    end
    serve(0, 0, 2'b00, -1, -1, -1);
    n_tests++;
    if (obs_wait != 0 || obs_acc !== 2'b10 || obs_addr !== a1 || obs_len !== 8'd2) begin
      n_fail++; $display("FAIL late_grant: wait %0d acc %b addr %h len %0d want 0 10 %h 2",
                         obs_wait, obs_acc, obs_addr, obs_len, a1);
    end
  endtask

  task automatic test_async_reset();
    int cnt, exp_w;
    s_araddr = {$urandom, $urandom};
    s_arlen  = {8'd0, 8'd15};
    s_arvalid = 2'b11;
    for (int k = 0; k < 2; k++) begin
      serve(0, 0, 2'b11, -1, -1, -1);
      n_tests++;
      if (obs_acc !== 2'b01) begin
        n_fail++; $display("FAIL arst_pre[%0d]: got %b want 01", k, obs_acc);
      end
    end
    serve(0, 0, 2'b11, -1, -1, 7);
    #2 arst = 1'b1;
    #1;
    n_tests++;
    if ({s_arready, s_rvalid, m_arvalid, m_rready, grant} !== 8'd0) begin
      n_fail++; $display("FAIL arst_outputs: got %b want 00000000",
                         {s_arready, s_rvalid, m_arvalid, m_rready, grant});
    end
    n_tests++;
    if (m_araddr !== '0 || m_arlen !== 8'd0) begin
      n_fail++; $display("FAIL arst_ar: got %h/%0d want 0/0", m_araddr, m_arlen);
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    @(negedge aclk);
    arst = 1'b0;
    s_arlen = {8'd1, 8'd1};
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      exp_w = (cnt == MC) ? 1 : 0;
      cnt   = (exp_w == 1) ? 0 : cnt + 1;
      serve(0, 0, 2'b11, -1, -1, -1);
      n_tests++;
      if (obs_to || obs_acc !== (exp_w == 1 ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL arst_post[%0d]: got %b want owner %0d", k, obs_acc, exp_w);
      end
    end
    s_arvalid = 2'b00;
  endtask

  task automatic test_back_to_back();
    int prev;
    s_araddr = {$urandom, $urandom};
    s_arlen  = 16'h0000;
    s_arvalid = 2'b10;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      serve(0, 0, 2'b10, -1, -1, -1);
      n_tests++;
      if (obs_to || obs_acc !== 2'b10 || obs_beat_bad != 0 || got.size() != 1 ||
          sent.size() != 1 || got[0] !== sent[0]) begin
        n_fail++; $display("FAIL b2b_beat[%0d]: acc %b beat_bad %0d got %0d beats want 10 0 1",
                           k, obs_acc, obs_beat_bad, got.size());
      end
      if (k > 0) begin
        n_tests++;
        if (obs_arv_cyc - prev != 3) begin
          n_fail++; $display("FAIL b2b_period[%0d]: got %0d cycles want 3",
                             k, obs_arv_cyc - prev);
        end
      end
      prev = obs_arv_cyc;
    end
    s_arvalid = 2'b00;
  endtask

  task automatic test_random_traffic();
    int cnt, exp_w, dmis;
    logic [1:0] mask;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      mask     = 2'($urandom_range(3, 1));
      s_araddr = {$urandom, $urandom};
      s_arlen  = {8'($urandom_range(7, 0)), 8'($urandom_range(7, 0))};
      s_arvalid = mask;
      if (mask == 2'b01) exp_w = 0;
      else if (mask == 2'b10) exp_w = 1;
      else exp_w = (cnt == MC) ? 1 : 0;
      if (exp_w == 0 && mask[1]) cnt = (cnt == MC) ? cnt : cnt + 1;
      else cnt = 0;
      serve(int'($urandom_range(3, 0)), 2, 2'b00, -1, -1, -1);
      n_tests++;
      if (obs_to || obs_acc !== (exp_w == 1 ? 2'b10 : 2'b01) || obs_gnt !== obs_acc ||
          obs_addr !== s_araddr[exp_w*AW +: AW] || obs_len !== s_arlen[exp_w*8 +: 8]) begin
        n_fail++; $display("FAIL rand_grant[%0d]: acc %b gnt %b addr %h len %0d want owner %0d",
                           k, obs_acc, obs_gnt, obs_addr, obs_len, exp_w);
      end
      dmis = (got.size() != sent.size() || sent.size() != int'(s_arlen[exp_w*8 +: 8]) + 1);
      foreach (sent[i]) if (i < got.size() && got[i] !== sent[i]) dmis++;
      n_tests++;
      if (dmis != 0 || obs_steer_bad != 0 || obs_beat_bad != 0) begin
        n_fail++; $display("FAIL rand_data[%0d]: mis %0d steer %0d beat %0d want 0 0 0",
                           k, dmis, obs_steer_bad, obs_beat_bad);
      end
      s_arvalid = 2'b00;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_priority();
    test_rready_stall();
    test_late_req1();
    test_async_reset();
    test_back_to_back();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
